// File: rtl/oddeven_sortn.sv
// Odd-even transposition sorter: accepts one vector, runs DATA_NUM parallel
// compare/swap phases, then holds the sorted data and original indices until taken.

module oddeven_cmp #(
   parameter int W      = 16,
   parameter int SIGNED = 0
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         gt,
   output logic         lt
);
   generate
      if (SIGNED != 0) begin : g_s
         assign gt = $signed(a) > $signed(b);
         assign lt = $signed(a) < $signed(b);
      end else begin : g_u
         assign gt = a > b;
         assign lt = a < b;
      end
   endgenerate
endmodule

module oddeven_sortn #(
   parameter int  FIX_POINT_WIDTH = 16,
   parameter int  DATA_NUM        = 8,
   parameter int  SIGNED          = 0,
   localparam int IDX_W           = (DATA_NUM > 1) ? $clog2(DATA_NUM) : 1
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic [DATA_NUM*FIX_POINT_WIDTH-1:0] in_data,
   input  logic                                descend,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [DATA_NUM*FIX_POINT_WIDTH-1:0] out_data,
   output logic [DATA_NUM*IDX_W-1:0]           out_idx,
   output logic                                busy
);
   localparam int W = FIX_POINT_WIDTH;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SORT = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]                         state;
   logic [DATA_NUM-1:0][W-1:0]         elem, elem_nx;
   logic [DATA_NUM-1:0][IDX_W-1:0]     idx, idx_nx;
   logic [IDX_W-1:0]                   phase;
   logic                               desc_q;
   logic [DATA_NUM-2:0]                gt, lt;

   genvar j;
   generate
      for (j = 0; j < DATA_NUM-1; j++) begin : g_cmp
         oddeven_cmp #(.W(W), .SIGNED(SIGNED)) u_cmp (
            .a  (elem[j]),
            .b  (elem[j+1]),
            .gt (gt[j]),
            .lt (lt[j])
         );
      end
   endgenerate

   // Pairs of one parity are disjoint, so all swaps read the phase-start values.
   always_comb begin
      elem_nx = elem;
      idx_nx  = idx;
      for (int k = 0; k < DATA_NUM-1; k++) begin
         if ((k % 2) == int'(phase[0]) && (desc_q ? lt[k] : gt[k])) begin
            elem_nx[k]   = elem[k+1];
            elem_nx[k+1] = elem[k];
            idx_nx[k]    = idx[k+1];
            idx_nx[k+1]  = idx[k];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         elem   <= '0;
         idx    <= '0;
         phase  <= '0;
         desc_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (in_valid) begin
               elem   <= in_data;
               for (int i = 0; i < DATA_NUM; i++) idx[i] <= IDX_W'(i);
               desc_q <= descend;
               phase  <= '0;
               state  <= S_SORT;
            end
            S_SORT: begin
               elem  <= elem_nx;
               idx   <= idx_nx;
               phase <= phase + 1'b1;
               if (phase == IDX_W'(DATA_NUM-1)) state <= S_DONE;
            end
            S_DONE: if (out_ready) state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = (state == S_IDLE) && !rst;
   assign out_valid = (state == S_DONE);
   assign busy      = (state == S_SORT);
   assign out_data  = elem;
   assign out_idx   = idx;
endmodule

// File: tb/tb_oddeven_sortn.sv
// Bench for oddeven_sortn: three instances (4 unsigned, 4 signed, 8 unsigned)
// checked against a stable insertion-sort reference model.

module tb_oddeven_sortn;
   typedef logic [15:0] vec_t [8];

   logic         clk = 0;
   logic         rst = 1;
   logic [2:0]   iv = '0, ordy = '0, dsc = '0;
   logic [2:0]   ir, ov, bsy;
   logic [63:0]  id0 = '0, id1 = '0, od0, od1;
   logic [127:0] id2 = '0, od2;
   logic [7:0]   oi0, oi1;
   logic [23:0]  oi2;
   int           total = 0, bad = 0;

   always #5 clk = ~clk;

   oddeven_sortn #(.FIX_POINT_WIDTH(16), .DATA_NUM(4), .SIGNED(0)) u0 (
      .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id0),
      .descend(dsc[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od0),
      .out_idx(oi0), .busy(bsy[0]));
   oddeven_sortn #(.FIX_POINT_WIDTH(16), .DATA_NUM(4), .SIGNED(1)) u1 (
      .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id1),
      .descend(dsc[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od1),
      .out_idx(oi1), .busy(bsy[1]));
   oddeven_sortn #(.FIX_POINT_WIDTH(16), .DATA_NUM(8), .SIGNED(0)) u2 (
      .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(id2),
      .descend(dsc[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od2),
      .out_idx(oi2), .busy(bsy[2]));

   task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
      total++;
      assert (o === e) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   function automatic logic [127:0] g_od(input int u);
      case (u)
         0:       return {64'b0, od0};
         1:       return {64'b0, od1};
         default: return od2;
      endcase
   endfunction

   function automatic logic [23:0] g_oi(input int u);
      case (u)
         0:       return {16'b0, oi0};
         1:       return {16'b0, oi1};
         default: return oi2;
      endcase
   endfunction

   task automatic set_in(input int u, input vec_t v);
      logic [127:0] p;
      p = '0;
      for (int i = 0; i < 8; i++) p[i*16 +: 16] = v[i];
      case (u)
         0:       id0 = p[63:0];
         1:       id1 = p[63:0];
         default: id2 = p;
      endcase
   endtask

   // Reference: stable insertion sort on integer keys, tracking original positions.
   task automatic ref_sort(input int n, input bit sgn, input bit d, input vec_t v,
                           output logic [127:0] ed, output logic [23:0] ei);
      int key [8];
      int ord [8];
      int iw, j;
      iw = (n == 8) ? 3 : 2;
      for (int i = 0; i < n; i++) key[i] = sgn ? int'($signed(v[i])) : int'({16'b0, v[i]});
      for (int i = 0; i < n; i++) begin
         j = i;
         while (j > 0 && (d ? key[i] > key[ord[j-1]] : key[i] < key[ord[j-1]])) begin
            ord[j] = ord[j-1];
            j--;
         end
         ord[j] = i;
      end
      ed = '0;
      ei = '0;
      for (int i = 0; i < n; i++) begin
         ed[i*16 +: 16] = v[ord[i]];
         ei = ei | (24'(ord[i]) << (i*iw));
      end
   endtask

   task automatic sort_check(input int u, input vec_t v, input bit d, input int hold,
                             input string tag);
      int n, c;
      logic [127:0] ed;
      logic [23:0]  ei;
      vec_t junk;
      n = (u == 2) ? 8 : 4;
      ref_sort(n, (u == 1), d, v, ed, ei);
      @(negedge clk);
      chk({tag, ".in_ready"}, ir[u], 1);
      set_in(u, v);
      dsc[u] = d;
      iv[u]  = 1;
      @(posedge clk); #1;
      iv[u]  = 0;
      dsc[u] = ~d;
      chk({tag, ".busy"}, bsy[u], 1);
      c = 0;
      while (!ov[u] && c < 40) begin
         @(posedge clk); #1;
         c++;
      end
      chk({tag, ".latency"}, c, n);
      chk({tag, ".data"}, g_od(u), ed);
      chk({tag, ".idx"}, g_oi(u), ei);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         for (int i = 0; i < 8; i++) junk[i] = 16'($urandom);
         set_in(u, junk);
         iv[u] = h[0];
         @(posedge clk); #1;
         chk({tag, ".hold_valid"}, ov[u], 1);
         chk({tag, ".hold_data"}, g_od(u), ed);
         chk({tag, ".hold_in_ready"}, ir[u], 0);
      end
      @(negedge clk);
      iv[u]   = 0;
      ordy[u] = 1;
      @(posedge clk); #1;
      ordy[u] = 0;
      chk({tag, ".post_in_ready"}, ir[u], 1);
      chk({tag, ".post_valid"}, ov[u], 0);
   endtask

   initial begin
      vec_t v;
      bit   d;
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      for (int u = 0; u < 3; u++) begin
         chk("rst.in_ready", ir[u], 0);
         chk("rst.out_valid", ov[u], 0);
         chk("rst.busy", bsy[u], 0);
         chk("rst.out_data", g_od(u), 0);
         chk("rst.out_idx", g_oi(u), 0);
      end
      rst = 0;
      #1;
      for (int u = 0; u < 3; u++) chk("rst.release_in_ready", ir[u], 1);

      // Unsigned ascending reverse input
      v = '{16'd4, 16'd3, 16'd2, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0};
      sort_check(0, v, 0, 0, "asc4");
      // Signedness on both 4-element instances
      v = '{16'h0001, 16'hFFFF, 16'h8000, 16'h7FFF, 16'd0, 16'd0, 16'd0, 16'd0};
      sort_check(1, v, 0, 0, "signed4");
      sort_check(0, v, 0, 0, "unsigned4");
      // Descending with ties (stability)
      v = '{16'd5, 16'd5, 16'd2, 16'd9, 16'd0, 16'd0, 16'd0, 16'd0};
      sort_check(0, v, 1, 0, "desc_ties");
      // Backpressure with ignored in_valid pulses
      v = '{16'd7, 16'd1, 16'd7, 16'd3, 16'd0, 16'd0, 16'd0, 16'd0};
      sort_check(0, v, 0, 10, "backpressure");
      // Eight elements, reversed
      v = '{16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
      sort_check(2, v, 0, 0, "asc8");

      // Reset during phase 2
      @(negedge clk);
      v = '{16'd4, 16'd3, 16'd2, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0};
      set_in(0, v);
      iv[0] = 1;
      @(posedge clk); #1;
      iv[0] = 0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1;
      @(posedge clk); #1;
      chk("midrst.busy", bsy[0], 0);
      chk("midrst.out_valid", ov[0], 0);
      chk("midrst.out_data", g_od(0), 0);
      chk("midrst.in_ready_in_rst", ir[0], 0);
      rst = 0;
      #1;
      chk("midrst.in_ready_after", ir[0], 1);
      @(posedge clk); #1;
      chk("midrst.no_valid", ov[0], 0);

      // Random regression: 8-element unsigned, then 4-element signed
      for (int t = 0; t < 1000; t++) begin
         for (int i = 0; i < 8; i++)
            v[i] = t[0] ? 16'($urandom_range(0, 5)) : 16'($urandom);
         d = 1'($urandom);
         sort_check(2, v, d, 0, "rnd8");
      end
      for (int t = 0; t < 200; t++) begin
         for (int i = 0; i < 8; i++)
            v[i] = t[0] ? 16'($urandom_range(0, 3) - 2) : 16'($urandom);
         d = 1'($urandom);
         sort_check(1, v, d, 0, "rnd4s");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/oddeven_sortn.md
ODDEVEN_SORTN -- requirements
Module: oddeven_sortn

Interface
REQ-001 SHALL have parameter FIX_POINT_WIDTH, default 16, element bit width.
REQ-002 SHALL have parameter DATA_NUM, default 8, element count; even, 2..64; other values are unsupported.
REQ-003 SHALL have parameter SIGNED, default 0; 1 = two's-complement compare, 0 = unsigned compare.
REQ-004 SHALL derive local IDX_W = clog2(DATA_NUM) (minimum 1).
REQ-005 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-007 SHALL have port in_valid  input  1  in_data is valid.
REQ-008 SHALL have port in_ready  output  1  block can accept a vector.
REQ-009 SHALL have port in_data  input  DATA_NUM*FIX_POINT_WIDTH  packed vector; element i at bits [i*W +: W].
REQ-010 SHALL have port descend  input  1  sort order, sampled only on accept: 0 = ascending, 1 = descending.
REQ-011 SHALL have port out_valid  output  1  out_data/out_idx hold a finished sort.
REQ-012 SHALL have port out_ready  input  1  consumer takes the result.
REQ-013 SHALL have port out_data  output  DATA_NUM*FIX_POINT_WIDTH  sorted vector, same packing; position 0 is first in sort order.
REQ-014 SHALL have port out_idx  output  DATA_NUM*IDX_W  original input index of each out_data element.
REQ-015 SHALL have port busy  output  1  high in SORT state.

Function
REQ-016 SHALL implement FSM IDLE -> SORT -> DONE -> IDLE.
REQ-017 SHALL drive in_ready = (state==IDLE) && !rst, as a combinational function of state and rst.
REQ-018 SHALL, on accept (in_valid && in_ready at edge k), load every element and index register i with in_data[i] and i, latch descend, clear the phase counter, and enter SORT.
REQ-019 SHALL run exactly DATA_NUM phases in SORT, one per cycle, at edges k+1..k+DATA_NUM.
REQ-020 SHALL use even phases (counter 0,2,...) on pairs (0,1),(2,3),...; odd phases use pairs (1,2),(3,4),...,(N-3,N-2); element 0 and element N-1 are idle in odd phases.
REQ-021 SHALL swap a pair (j,j+1), data and index together, only when strictly out of order: ascending swaps if e[j] > e[j+1]; descending swaps if e[j] < e[j+1]; equal keys never swap, so the sort is stable.
REQ-022 SHALL apply all comparisons in one phase in parallel on register values from the start of that phase.
REQ-023 SHALL compare signed when SIGNED=1 and unsigned otherwise, with no width extension of the stored data.
REQ-024 SHALL enter DONE at edge k+DATA_NUM, so out_valid is first high in the cycle after that edge; fixed latency is DATA_NUM cycles after accept.
REQ-025 SHALL hold out_valid, out_data and out_idx stable in DONE until out_ready is high at an edge, then return to IDLE; in_ready is high the following cycle.
REQ-026 SHALL ignore in_valid, in_data and descend while in SORT or DONE; no accept occurs in the handoff cycle from DONE to IDLE.
REQ-027 SHALL drive out_data and out_idx from the working registers at all times; their values are meaningful only while out_valid is high.
REQ-028 SHALL keep out_valid low in IDLE and SORT, and busy high only in SORT.

Reset
REQ-029 SHALL, while rst is high at an edge, set state IDLE, all element registers to 0, index registers to 0, phase counter to 0 and latched descend to 0.
REQ-030 SHALL have, after reset: out_valid=0, busy=0, out_data=0, out_idx=0; in_ready=0 while rst is high and 1 in the first cycle after rst falls.
REQ-031 SHALL abort any sort in progress (SORT or DONE) when rst is asserted, discarding its data, with no out_valid pulse.
REQ-032 SHALL give rst priority over every simultaneous in_valid or out_ready event.

Verification (DATA_NUM=4, W=16 unless stated)
REQ-033 SHALL cover unsigned ascending: accept [4,3,2,1] at edge k -> out_valid from edge k+4; out_data [1,2,3,4]; out_idx [3,2,1,0].
REQ-034 SHALL cover signedness: [0x0001,0xFFFF,0x8000,0x7FFF] with SIGNED=1 -> [0x8000,0xFFFF,0x0001,0x7FFF]; with SIGNED=0 -> [0x0001,0x7FFF,0x8000,0xFFFF].
REQ-035 SHALL cover descending with ties: descend=1, [5,5,2,9] -> out_data [9,5,5,2]; out_idx [3,0,1,2] (stability).
REQ-036 SHALL cover backpressure: out_ready low for 10 cycles in DONE -> out_valid held, outputs unchanged, in_ready=0 and in_valid pulses ignored; then out_ready=1 -> in_ready=1 the next cycle.
REQ-037 SHALL cover reset mid-sort: rst during phase 2 -> next cycle busy=0, out_valid=0, out_data=0, and in_ready=1 the first cycle after rst drops.
REQ-038 SHALL cover DATA_NUM=8: [8,7,6,5,4,3,2,1] -> [1..8] after exactly 8 cycles; random regression of 1000 vectors checked against a reference stable sort.
